// File: rtl/prm_pkg.sv
// Shared types and constants for the blocked-edge accumulator around the
// prm_oblgc_chk edge-checker bank.
package prm_pkg;

  localparam int unsigned OBS_CODE_W    = 15;
  localparam int unsigned NUM_EDGES_DEF = 1024;
  localparam int unsigned SLICE_W_DEF   = 32;

  typedef enum logic [1:0] {
    StAccum,
    StFlush,
    StCount,
    StDone
  } prm_state_e;

  // Bits needed to hold a population count of n bits, including the all-set case.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prm_popcnt_slice.sv
// Combinational population count of one SLICE_W-bit slice of the edge bitmap.
module prm_popcnt_slice
  import prm_pkg::*;
#(
  parameter int unsigned SLICE_W = SLICE_W_DEF,
  localparam int unsigned PC_W   = count_width(SLICE_W)
) (
  input  logic [SLICE_W-1:0] bits,
  output logic [PC_W-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Frame sequencer: feeds obstacle codes to the checker bank, ORs the returned edge
// masks into a blocked-edge bitmap and hands bitmap plus popcount to the planner.
module prm_edge_mask_accum
  import prm_pkg::*;
#(
  parameter int unsigned NUM_EDGES = NUM_EDGES_DEF,
  parameter int unsigned SLICE_W   = SLICE_W_DEF,
  parameter int unsigned CELL_W    = 16,
  localparam int unsigned CNT_W    = count_width(NUM_EDGES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  obs_valid,
  output logic                  obs_ready,
  input  logic [OBS_CODE_W-1:0] obs_code,
  input  logic                  obs_last,
  output logic [OBS_CODE_W-1:0] chk_code,
  input  logic [NUM_EDGES-1:0]  edge_mask_vec,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [NUM_EDGES-1:0]  blk_mask,
  output logic [CNT_W-1:0]      blk_count,
  output logic [CELL_W-1:0]     blk_cells
);

  localparam int unsigned NUM_SLICES    = NUM_EDGES / SLICE_W;
  localparam int unsigned IDX_W         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int unsigned PC_W          = count_width(SLICE_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  prm_state_e              state_q, state_d;
  logic [OBS_CODE_W-1:0]   chk_code_q, chk_code_d;
  logic                    pend_q, pend_d;
  logic [NUM_EDGES-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CELL_W-1:0]       cells_q, cells_d;
  logic                    valid_q, valid_d;

  logic [NUM_SLICES-1:0][SLICE_W-1:0] acc_slices;
  logic [SLICE_W-1:0]                 cur_slice;
  logic [PC_W-1:0]                    slice_cnt;

  assign acc_slices = acc_q;
  assign cur_slice  = acc_slices[idx_q];

  prm_popcnt_slice #(
    .SLICE_W(SLICE_W)
  ) u_popcnt (
    .bits (cur_slice),
    .count(slice_cnt)
  );

  always_comb begin
    state_d    = state_q;
    chk_code_d = chk_code_q;
    pend_d     = pend_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cells_d    = cells_q;
    valid_d    = valid_q;

    unique case (state_q)
      StAccum: begin
        // The bank output reflects the code registered on the previous cycle.
        if (pend_q) acc_d = acc_q | edge_mask_vec;
        if (obs_valid) begin
          chk_code_d = obs_code;
          pend_d     = 1'b1;
          if (cells_q != '1) cells_d = cells_q + CELL_W'(1);
          if (obs_last) state_d = StFlush;
        end else begin
          pend_d = 1'b0;
        end
      end
      StFlush: begin
        if (pend_q) acc_d = acc_q | edge_mask_vec;
        pend_d  = 1'b0;
        idx_d   = '0;
        state_d = StCount;
      end
      StCount: begin
        cnt_d = cnt_q + CNT_W'(slice_cnt);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = StDone;
      end
      StDone: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (blk_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          cells_d = '0;
          pend_d  = 1'b0;
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StAccum;
      chk_code_q <= '0;
      pend_q     <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      cells_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_code_q <= chk_code_d;
      pend_q     <= pend_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cells_q    <= cells_d;
      valid_q    <= valid_d;
    end
  end

  assign obs_ready = (state_q == StAccum);
  assign chk_code  = chk_code_q;
  assign blk_valid = valid_q;
  assign blk_mask  = acc_q;
  assign blk_count = cnt_q;
  assign blk_cells = cells_q;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Bench for prm_edge_mask_accum at NUM_EDGES=64, SLICE_W=16 with a modelled checker bank.
module tb_prm_edge_mask_accum;

  localparam int unsigned NE  = 64;
  localparam int unsigned SW  = 16;
  localparam int          LAT = 2 + NE / SW;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        obs_valid = 1'b0;
  logic        obs_ready;
  logic [14:0] obs_code = '0;
  logic        obs_last = 1'b0;
  logic [14:0] chk_code;
  logic [63:0] edge_mask_vec;
  logic        blk_valid;
  logic        blk_ready = 1'b0;
  logic [63:0] blk_mask;
  logic [6:0]  blk_count;
  logic [15:0] blk_cells;

  int checks = 0;
  int errors = 0;

  prm_edge_mask_accum #(
    .NUM_EDGES(NE),
    .SLICE_W  (SW),
    .CELL_W   (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .obs_valid    (obs_valid),
    .obs_ready    (obs_ready),
    .obs_code     (obs_code),
    .obs_last     (obs_last),
    .chk_code     (chk_code),
    .edge_mask_vec(edge_mask_vec),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_mask     (blk_mask),
    .blk_count    (blk_count),
    .blk_cells    (blk_cells)
  );

  always #5 CLK = ~CLK;

  // Checker bank model: a few hand-picked codes, a sparse hash for everything else.
  function automatic logic [63:0] mask_of(input logic [14:0] c);
    logic [63:0] h1, h2;
    case (c)
      15'h4A31: return 64'h0000_0000_0000_00F1;
      15'h0001: return 64'h0000_0000_0000_0001;
      15'h0002: return 64'h8000_0000_0000_0000;
      15'h0003: return 64'h0000_0000_0000_0002;
      15'h0010: return 64'h0000_0000_0000_FFFF;
      15'h0011: return 64'h0000_0000_FFFF_0000;
      15'h0012: return 64'h0000_FFFF_0000_0000;
      15'h0013: return 64'hFFFF_0000_0000_0000;
      default: begin
        h1 = {49'b0, c} * 64'h9E37_79B9_7F4A_7C15;
        h2 = (h1 ^ (h1 >> 29)) * 64'hBF58_476D_1CE4_E5B9;
        return h2 & (h2 >> 17);
      end
    endcase
  endfunction

  assign edge_mask_vec = mask_of(chk_code);

  function automatic logic [63:0] frame_mask(input logic [14:0] codes[$]);
    logic [63:0] m = '0;
    foreach (codes[i]) m |= mask_of(codes[i]);
    return m;
  endfunction

  // Drives one frame; returns the time of the edge that accepted the last beat.
  task automatic send_frame(input logic [14:0] codes[$], input bit gaps, output time t_last);
    t_last = 0;
    foreach (codes[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          obs_valid = 1'b0;
          obs_code  = 15'($urandom);
          obs_last  = 1'($urandom);
          @(posedge CLK);
          #1;
        end
      end
      obs_valid = 1'b1;
      obs_code  = codes[i];
      obs_last  = (i == codes.size() - 1);
      @(posedge CLK);
      t_last = $time;
      #1;
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
  endtask

  // Returns the edge count from t0 to the first edge after which blk_valid is high, or -1.
  task automatic wait_valid(input time t0, output int k);
    k = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (blk_valid === 1'b1) begin
        k = int'(($time - t0 - 5) / 10);
        break;
      end
    end
  endtask

  task automatic consume();
    blk_ready = 1'b1;
    @(posedge CLK);
    #1;
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] q[$];
    time t;
    bit seen;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || blk_valid !== 1'b0 || blk_count !== 7'd0 || chk_code !== 15'd0 ||
        blk_mask !== 64'd0 || blk_cells !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b cnt=%0d code=%h mask=%h cells=%0d, want 1 0 0 0 0 0",
               obs_ready, blk_valid, blk_count, chk_code, blk_mask, blk_cells);
    end
    q = '{15'h1234};
    send_frame(q, 1'b0, t);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || blk_valid !== 1'b0 || blk_count !== 7'd0 || chk_code !== 15'd0 ||
        blk_cells !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_count: rdy=%b vld=%b cnt=%0d code=%h cells=%0d, want 1 0 0 0 0",
               obs_ready, blk_valid, blk_count, chk_code, blk_cells);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (blk_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_result: blk_valid seen=%b, want 0", seen);
    end
  endtask

  task automatic test_single();
    logic [14:0] q[$];
    time t;
    int k;
    q = '{15'h4A31};
    send_frame(q, 1'b0, t);
    wait_valid(t, k);
    checks++;
    if (k !== LAT) begin
      errors++;
      $display("FAIL single_latency: got %0d edges, want %0d", k, LAT);
    end
    checks++;
    if (blk_mask !== 64'hF1 || blk_count !== 7'd5 || blk_cells !== 16'd1) begin
      errors++;
      $display("FAIL single_result: mask=%h cnt=%0d cells=%0d, want f1 5 1",
               blk_mask, blk_count, blk_cells);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [14:0] q[$];
    time t;
    int k;
    int low_bad;
    q = '{15'h0001, 15'h0002, 15'h0001};
    send_frame(q, 1'b0, t);
    k = -1;
    low_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (obs_ready !== 1'b0) low_bad++;
      if (blk_valid === 1'b1) begin
        k = int'(($time - t - 5) / 10);
        break;
      end
    end
    checks++;
    if (k !== LAT || low_bad != 0) begin
      errors++;
      $display("FAIL b2b_timing: latency=%0d ready_high_cycles=%0d, want %0d 0", k, low_bad, LAT);
    end
    checks++;
    if (blk_mask !== 64'h8000_0000_0000_0001 || blk_count !== 7'd2 || blk_cells !== 16'd3) begin
      errors++;
      $display("FAIL b2b_result: mask=%h cnt=%0d cells=%0d, want 8000000000000001 2 3",
               blk_mask, blk_count, blk_cells);
    end
    consume();
    @(negedge CLK);
    checks++;
    if (obs_ready !== 1'b1 || blk_valid !== 1'b0 || blk_count !== 7'd0 || blk_mask !== 64'd0) begin
      errors++;
      $display("FAIL b2b_release: rdy=%b vld=%b cnt=%0d mask=%h, want 1 0 0 0",
               obs_ready, blk_valid, blk_count, blk_mask);
    end
  endtask

  task automatic test_gaps();
    logic [14:0] q[$];
    logic [63:0] em;
    time t;
    int k;
    for (int f = 0; f < 4; f++) begin
      q.delete();
      repeat ($urandom_range(1, 6)) q.push_back(15'($urandom));
      em = frame_mask(q);
      send_frame(q, 1'b1, t);
      wait_valid(t, k);
      checks++;
      if (k !== LAT) begin
        errors++;
        $display("FAIL gaps_latency[%0d]: got %0d, want %0d", f, k, LAT);
      end
      checks++;
      if (blk_mask !== em || blk_count !== 7'($countones(em)) || blk_cells !== 16'(q.size())) begin
        errors++;
        $display("FAIL gaps_result[%0d]: mask=%h cnt=%0d cells=%0d, want %h %0d %0d", f,
                 blk_mask, blk_count, blk_cells, em, $countones(em), q.size());
      end
      consume();
    end
  endtask

  task automatic test_hold();
    logic [14:0] q[$];
    logic [63:0] em;
    time t;
    int k;
    q = '{15'($urandom), 15'($urandom)};
    em = frame_mask(q);
    send_frame(q, 1'b0, t);
    wait_valid(t, k);
    checks++;
    if (k !== LAT) begin
      errors++;
      $display("FAIL hold_latency: got %0d, want %0d", k, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      obs_valid = 1'b1;
      obs_code  = 15'($urandom);
      obs_last  = 1'b1;
      @(negedge CLK);
      checks++;
      if (blk_valid !== 1'b1 || obs_ready !== 1'b0 || blk_mask !== em ||
          blk_count !== 7'($countones(em)) || blk_cells !== 16'd2) begin
        errors++;
        $display("FAIL hold_stable[%0d]: vld=%b rdy=%b mask=%h cnt=%0d cells=%0d, want 1 0 %h %0d 2",
                 i, blk_valid, obs_ready, blk_mask, blk_count, blk_cells, em, $countones(em));
      end
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    consume();
    q = '{15'h0003};
    send_frame(q, 1'b0, t);
    wait_valid(t, k);
    checks++;
    if (k !== LAT || blk_mask !== 64'h2 || blk_count !== 7'd1 || blk_cells !== 16'd1) begin
      errors++;
      $display("FAIL hold_next: lat=%0d mask=%h cnt=%0d cells=%0d, want %0d 2 1 1",
               k, blk_mask, blk_count, blk_cells, LAT);
    end
    consume();
  endtask

  task automatic test_full();
    logic [14:0] q[$];
    time t;
    int k;
    q = '{15'h0012, 15'h0010, 15'h0013, 15'h0011, 15'h0010};
    send_frame(q, 1'b1, t);
    wait_valid(t, k);
    checks++;
    if (k !== LAT || blk_mask !== '1 || blk_count !== 7'd64 || blk_cells !== 16'd5) begin
      errors++;
      $display("FAIL full_count: lat=%0d mask=%h cnt=%0d cells=%0d, want %0d all-ones 64 5",
               k, blk_mask, blk_count, blk_cells, LAT);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_hold();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prm_edge_mask_accum.md
Name: prm_edge_mask_accum

Overview:
- Frame sequencer that wraps the bank of combinational prm_oblgc_chk* edge checkers.
- Accepts a stream of occupied-cell obstacle codes, one 15-bit code per beat, bits O..A of the checker inputs.
- Drives each code into the checker bank and ORs the returned edge_mask vector into a blocked-edge bitmap.
- At frame end it counts the blocked edges and presents bitmap plus count to the roadmap planner through a valid/ready handshake.

Parameters:
- NUM_EDGES, 1024: number of edge checkers; width of the mask vector.
- SLICE_W, 32: bits counted per cycle in the COUNT state. NUM_EDGES must be a multiple of SLICE_W.
- CELL_W, 16: width of the frame cell counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- obs_valid  in  1  obstacle code beat valid.
- obs_ready  out  1  block accepts a beat.
- obs_code  in  15  occupied-cell code, bit14=O ... bit0=A.
- obs_last  in  1  last beat of the frame.
- chk_code  out  15  registered code fed to all checker inputs O..A.
- edge_mask_vec  in  NUM_EDGES  concatenated edge_mask outputs of the bank; combinational function of chk_code.
- blk_valid  out  1  result available.
- blk_ready  in  1  planner consumes result.
- blk_mask  out  NUM_EDGES  blocked-edge bitmap.
- blk_count  out  clog2(NUM_EDGES+1)  number of set bits in blk_mask.
- blk_cells  out  CELL_W  number of beats in the frame, saturating at all-ones.

Behaviour:
- One clock CLK; reset is synchronous and active-high on RST.
- Reset values:
  - state=ACCUM, obs_ready=1, blk_valid=0.
  - acc/blk_mask=0, blk_count=0, blk_cells=0.
  - chk_code=0, pend=0, slice index=0.
- States: ACCUM, FLUSH, COUNT, DONE. obs_ready = (state==ACCUM).
- ACCUM:
  - On obs_valid&obs_ready: chk_code<=obs_code, pend<=1, blk_cells<=sat(blk_cells+1).
  - Any cycle with pend=1: acc<=acc|edge_mask_vec. This is the mask of the code registered in the previous cycle.
  - pend<=0 on cycles with no handshake.
  - Back-to-back beats give one code per cycle with no bubbles.
  - A handshake with obs_last=1 moves to FLUSH.
- FLUSH (exactly one cycle): OR the mask of the last code, pend<=0, slice index<=0, go to COUNT.
- COUNT:
  - blk_count += popcount(acc[idx*SLICE_W +: SLICE_W]); idx++.
  - After slice NUM_EDGES/SLICE_W-1, go to DONE.
  - acc is frozen.
- DONE:
  - blk_valid=1; blk_mask, blk_count and blk_cells are held stable.
  - On blk_ready: blk_valid<=0; acc, blk_count, blk_cells and pend cleared; go to ACCUM.
  - obs_ready returns high the cycle after the handshake.
- Latency: last beat accepted at edge t → blk_valid high from edge t+2+NUM_EDGES/SLICE_W. Defaults give t+34.
- obs_code/obs_last are ignored when obs_ready=0. The upstream source must hold its beat, per the valid/ready rules.
- chk_code keeps its last value between frames. Only pend gates accumulation, so stale masks never OR in.
- Duplicate codes within a frame are legal and idempotent in acc; blk_cells still counts each one.
- blk_cells saturates at 2^CELL_W-1; no wrap.
- blk_count maximum is NUM_EDGES, which its width holds exactly.
- RST asserted in any state aborts the frame and returns all registers to reset values on that edge. No partial result is emitted.
- The bank is purely combinational. edge_mask_vec is sampled one cycle after chk_code updates; no other timing is assumed.

Decomposition:
- Package prm_pkg holds:
  - OBS_CODE_W=15.
  - The state enum {ACCUM, FLUSH, COUNT, DONE}.
  - Default NUM_EDGES and SLICE_W.
  - The function computing the count width.
- Sub-module prm_popcnt_slice: combinational popcount of SLICE_W bits to clog2(SLICE_W+1) bits, instantiated once.

Test Plan:
Run the bench with NUM_EDGES=64 and SLICE_W=16. A behavioural checker-bank model maps each code to a fixed 64-bit mask.
1. Reset → obs_ready=1, blk_valid=0, blk_count=0, chk_code=0. RST mid-COUNT → same values next cycle, and no blk_valid ever asserts for that frame.
2. Single-beat frame, code 15'h4A31 with mask 64'h0000_0000_0000_00F1 → blk_valid at t+6, blk_mask=64'hF1, blk_count=5, blk_cells=1.
3. Three back-to-back beats with masks 64'h1, 64'h8000_0000_0000_0000, 64'h1 → blk_mask=64'h8000_0000_0000_0001, blk_count=2, blk_cells=3; obs_ready low from FLUSH until DONE handshake+1.
4. obs_valid toggling with gaps between beats (idle cycles while chk_code holds its value) → acc equals the OR of the accepted codes' masks only; no extra ORs.
5. blk_ready held low for 10 cycles in DONE → outputs stable and obs_ready=0 throughout. Release → acc cleared; next frame with mask 64'h2 gives blk_count=1.
6. Frame where all masks together cover all ones → blk_count=64, at maximum width, without overflow.
